// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared definitions for the common data bus (CDB): default tag/data widths,
// the source IDs that tag each broadcast with its functional unit, the bus
// struct the reservation stations consume, and the round-robin helpers used by
// the CDB arbiter.
// -----------------------------------------------------------------------------
package cdb_pkg;

    localparam int TAG_W   = 5;
    localparam int DATA_W  = 32;
    localparam int NUM_SRC = 3;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MUL = 2'd1,
        SRC_LSU = 2'd2
    } cdb_src_e;

    typedef struct packed {
        logic              en;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        cdb_src_e          src;
    } cdb_bus_t;

    // (a + b) mod 3 for operands in 0..2.
    function automatic logic [1:0] wrap3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    // Round-robin search starting at ptr. Returns {found, index}. The loop runs
    // from the farthest offset down so the nearest requester overwrites last.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            idx = wrap3(ptr, 2'(i));
            if (req[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// -----------------------------------------------------------------------------
// cdb_result_fifo
// Per-functional-unit result queue feeding the CDB arbiter.
//   clk_i, reset_i      clock, asynchronous active-high reset
//   flush_i             synchronous flush, empties the queue, beats push/pop
//   push_i, tag_i,      enqueue a result (ignored while full)
//   data_i
//   pop_i               dequeue the head (ignored while empty)
//   head_tag_o,         oldest entry, meaningful only when count_o != 0
//   head_data_o
//   count_o, full_o     registered occupancy
// -----------------------------------------------------------------------------
module cdb_result_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 5,
    parameter int DATA_W     = 32,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [TAG_W-1:0]  head_tag_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o
);

    logic [TAG_W+DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign full_o  = (count_o == CNT_W'(FIFO_DEPTH));
    // Full blocks a push even when the head leaves in the same cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && (count_o != '0) && !flush_i;

    assign {head_tag_o, head_data_o} = mem[rd_ptr];

    // Storage carries no reset; only entries below count_o are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= {tag_i, data_i};
        end
    end

    // Depth is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Producer end of the common data bus. Buffers ALU/MUL/LSU results in one
// queue each and broadcasts one result per cycle, chosen round-robin, on
// registered CDB outputs.
//   clk_i, reset_i, flush_i             clock, async active-high reset, sync flush
//   {alu,mul,lsu}_valid_i/_tag_i/_data_i  FU writeback results
//   {alu,mul,lsu}_ready_o                 queue has room (registered count only)
//   cdb_en_o, cdb_tag_o, cdb_data_o,      broadcast; src 0=ALU 1=MUL 2=LSU
//   cdb_src_o
// Build option: define CDB_BYPASS_EN to let a result arriving at an empty
// queue compete in the same cycle (1-cycle latency); otherwise only queue
// heads compete (2-cycle latency).
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = cdb_pkg::TAG_W,
    parameter int DATA_W     = cdb_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              alu_valid_i,
    input  logic [TAG_W-1:0]  alu_tag_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_ready_o,
    input  logic              mul_valid_i,
    input  logic [TAG_W-1:0]  mul_tag_i,
    input  logic [DATA_W-1:0] mul_data_i,
    output logic              mul_ready_o,
    input  logic              lsu_valid_i,
    input  logic [TAG_W-1:0]  lsu_tag_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    output logic              lsu_ready_o,
    output logic              cdb_en_o,
    output logic [TAG_W-1:0]  cdb_tag_o,
    output logic [DATA_W-1:0] cdb_data_o,
    output logic [1:0]        cdb_src_o
);

    import cdb_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]        in_valid;
    logic [TAG_W-1:0]  in_tag    [3];
    logic [DATA_W-1:0] in_data   [3];
    logic [TAG_W-1:0]  head_tag  [3];
    logic [DATA_W-1:0] head_data [3];
    logic [CNT_W-1:0]  q_count   [3];
    logic [2:0]        q_full;
    logic [2:0]        q_push;
    logic [2:0]        q_pop;
    logic [2:0]        bypass;
    logic [2:0]        cand;
    logic [2:0]        pick;
    logic              grant;
    logic [1:0]        win;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;
    logic [1:0]        rr_ptr;

    assign in_valid         = {lsu_valid_i, mul_valid_i, alu_valid_i};
    assign in_tag[SRC_ALU]  = alu_tag_i;
    assign in_tag[SRC_MUL]  = mul_tag_i;
    assign in_tag[SRC_LSU]  = lsu_tag_i;
    assign in_data[SRC_ALU] = alu_data_i;
    assign in_data[SRC_MUL] = mul_data_i;
    assign in_data[SRC_LSU] = lsu_data_i;

    assign alu_ready_o = !q_full[SRC_ALU];
    assign mul_ready_o = !q_full[SRC_MUL];
    assign lsu_ready_o = !q_full[SRC_LSU];

    for (genvar g = 0; g < 3; g++) begin : g_queue
        cdb_result_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .TAG_W      (TAG_W),
            .DATA_W     (DATA_W)
        ) u_fifo (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .flush_i     (flush_i),
            .push_i      (q_push[g]),
            .tag_i       (in_tag[g]),
            .data_i      (in_data[g]),
            .pop_i       (q_pop[g]),
            .head_tag_o  (head_tag[g]),
            .head_data_o (head_data[g]),
            .count_o     (q_count[g]),
            .full_o      (q_full[g])
        );
    end

    // Candidate selection, winner mux and per-queue push/pop. A bypassed
    // winner skips the queue entirely; a bypass candidate that loses is
    // enqueued like any other result. Flush suppresses the grant.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
`ifdef CDB_BYPASS_EN
            bypass[i] = (q_count[i] == '0) && in_valid[i];
`else
            bypass[i] = 1'b0;
`endif
            cand[i] = (q_count[i] != '0) || bypass[i];
        end
        pick     = rr_pick(cand, rr_ptr);
        grant    = pick[2] && !flush_i;
        win      = pick[1:0];
        win_tag  = bypass[win] ? in_tag[win]  : head_tag[win];
        win_data = bypass[win] ? in_data[win] : head_data[win];
        for (int i = 0; i < 3; i++) begin
            q_pop[i]  = grant && (win == 2'(i)) && !bypass[i];
            q_push[i] = in_valid[i] && !q_full[i]
                        && !(grant && (win == 2'(i)) && bypass[i]);
        end
    end

    // Broadcast registers and round-robin pointer. Idle cycles drop the
    // enable but keep the last tag/data/src on the bus.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr     <= 2'd0;
            cdb_en_o   <= 1'b0;
            cdb_tag_o  <= '0;
            cdb_data_o <= '0;
            cdb_src_o  <= SRC_ALU;
        end else if (flush_i) begin
            rr_ptr   <= 2'd0;
            cdb_en_o <= 1'b0;
        end else if (grant) begin
            rr_ptr     <= wrap3(win, 2'd1);
            cdb_en_o   <= 1'b1;
            cdb_tag_o  <= win_tag;
            cdb_data_o <= win_data;
            cdb_src_o  <= win;
        end else begin
            cdb_en_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed bench for cdb_arbiter. Expected broadcasts are queued when the
// stimulus is planned; a monitor pops one entry per broadcast and compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cdb_arbiter;

    import cdb_pkg::*;

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] data;
        logic [1:0]  src;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        alu_valid_i, mul_valid_i, lsu_valid_i;
    logic [4:0]  alu_tag_i, mul_tag_i, lsu_tag_i;
    logic [31:0] alu_data_i, mul_data_i, lsu_data_i;
    logic        alu_ready_o, mul_ready_o, lsu_ready_o;
    logic        cdb_en_o;
    logic [4:0]  cdb_tag_o;
    logic [31:0] cdb_data_o;
    logic [1:0]  cdb_src_o;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    cdb_arbiter #(.FIFO_DEPTH(4), .TAG_W(5), .DATA_W(32)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .alu_valid_i (alu_valid_i),
        .alu_tag_i   (alu_tag_i),
        .alu_data_i  (alu_data_i),
        .alu_ready_o (alu_ready_o),
        .mul_valid_i (mul_valid_i),
        .mul_tag_i   (mul_tag_i),
        .mul_data_i  (mul_data_i),
        .mul_ready_o (mul_ready_o),
        .lsu_valid_i (lsu_valid_i),
        .lsu_tag_i   (lsu_tag_i),
        .lsu_data_i  (lsu_data_i),
        .lsu_ready_o (lsu_ready_o),
        .cdb_en_o    (cdb_en_o),
        .cdb_tag_o   (cdb_tag_o),
        .cdb_data_o  (cdb_data_o),
        .cdb_src_o   (cdb_src_o)
    );

    // 10 ns clock.
    always #5 clk_i = ~clk_i;

    // Data word encodes source and tag so a swapped payload is visible.
    function automatic logic [31:0] mk_data(input logic [1:0] src, input logic [4:0] tag);
        return {8'hD0, 14'h0, src, 3'b000, tag};
    endfunction

    function automatic void expect_bc(input logic [1:0] src, input logic [4:0] tag);
        exp_t e;
        e.tag  = tag;
        e.data = mk_data(src, tag);
        e.src  = src;
        exp_q.push_back(e);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one cycle of inputs (active edge included), then return to idle.
    task automatic applyStimulus(input logic [2:0] valid, input logic [4:0] a_tag,
                                 input logic [4:0] m_tag, input logic [4:0] l_tag,
                                 input logic flush);
        alu_valid_i = valid[0];
        alu_tag_i   = a_tag;
        alu_data_i  = mk_data(SRC_ALU, a_tag);
        mul_valid_i = valid[1];
        mul_tag_i   = m_tag;
        mul_data_i  = mk_data(SRC_MUL, m_tag);
        lsu_valid_i = valid[2];
        lsu_tag_i   = l_tag;
        lsu_data_i  = mk_data(SRC_LSU, l_tag);
        flush_i     = flush;
        tick();
        alu_valid_i = 1'b0;
        mul_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic doReset();
        reset_i     = 1'b1;
        flush_i     = 1'b0;
        alu_valid_i = 1'b0;
        mul_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        #12;
        tick();
        reset_i = 1'b0;
    endtask

    // Wait (bounded) for every expected broadcast to appear.
    task automatic waitDrain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            tick();
        end
        checkOutput(name, 64'(exp_q.size()), 64'd0);
        repeat (3) tick();
    endtask

    // Monitor: every broadcast must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (!reset_i && cdb_en_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_bcast: got tag %0h src %0h expected no broadcast at %0t",
                         cdb_tag_o, cdb_src_o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                if ({cdb_tag_o, cdb_data_o, cdb_src_o} !== {mon_e.tag, mon_e.data, mon_e.src}) begin
                    bad++;
                    $display("[TB] FAIL bcast: got tag %0h data %0h src %0h expected tag %0h data %0h src %0h at %0t",
                             cdb_tag_o, cdb_data_o, cdb_src_o, mon_e.tag, mon_e.data, mon_e.src, $time);
                end
            end
        end
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a_tag, m_tag, l_tag;
        int a_cnt, m_cnt, l_cnt;
        logic [2:0] acc;
        exp_t e;

        // Reset state, observed while reset is held.
        reset_i     = 1'b1;
        flush_i     = 1'b0;
        alu_valid_i = 1'b0;
        mul_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        alu_tag_i   = '0;
        mul_tag_i   = '0;
        lsu_tag_i   = '0;
        alu_data_i  = '0;
        mul_data_i  = '0;
        lsu_data_i  = '0;
        #3;
        checkOutput("rst_en",    64'(cdb_en_o),   64'd0);
        checkOutput("rst_tag",   64'(cdb_tag_o),  64'd0);
        checkOutput("rst_data",  64'(cdb_data_o), 64'd0);
        checkOutput("rst_src",   64'(cdb_src_o),  64'd0);
        checkOutput("rst_ready", 64'({lsu_ready_o, mul_ready_o, alu_ready_o}), 64'b111);

`ifdef CDB_BYPASS_EN
        // Lone LSU result on empty queues goes out after one edge.
        doReset();
        expect_bc(SRC_LSU, 5'd3);
        applyStimulus(3'b100, 5'd0, 5'd0, 5'd3, 1'b0);
        checkOutput("byp_lat_en",  64'(cdb_en_o),  64'd1);
        checkOutput("byp_lat_tag", 64'(cdb_tag_o), 64'd3);
        // rr_ptr is back at ALU: ALU bypasses, LSU waits one cycle.
        expect_bc(SRC_ALU, 5'd4);
        expect_bc(SRC_LSU, 5'd3);
        applyStimulus(3'b101, 5'd4, 5'd0, 5'd3, 1'b0);
        checkOutput("byp_race_src0", 64'(cdb_src_o), 64'(SRC_ALU));
        tick();
        checkOutput("byp_race_en1",  64'(cdb_en_o),  64'd1);
        checkOutput("byp_race_src1", 64'(cdb_src_o), 64'(SRC_LSU));
        waitDrain("byp_drain", 20);
`else
        // Single ALU result: broadcast exactly two edges after acceptance.
        doReset();
        e.tag  = 5'd7;
        e.data = 32'hDEAD_BEEF;
        e.src  = SRC_ALU;
        exp_q.push_back(e);
        alu_valid_i = 1'b1;
        alu_tag_i   = 5'd7;
        alu_data_i  = 32'hDEAD_BEEF;
        tick();
        alu_valid_i = 1'b0;
        checkOutput("single_en_n",  64'(cdb_en_o), 64'd0);
        tick();
        checkOutput("single_en_n1", 64'(cdb_en_o), 64'd1);
        tick();
        checkOutput("single_en_n2", 64'(cdb_en_o), 64'd0);
        waitDrain("single_drain", 10);

        // Fairness: 4 results per FU pushed together, strict rotation, no gaps.
        doReset();
        for (int k = 1; k <= 4; k++) begin
            expect_bc(SRC_ALU, 5'(k));
            expect_bc(SRC_MUL, 5'(8 + k));
            expect_bc(SRC_LSU, 5'(16 + k));
        end
        for (int k = 1; k <= 13; k++) begin
            if (k <= 4) applyStimulus(3'b111, 5'(k), 5'(8 + k), 5'(16 + k), 1'b0);
            else        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
            if (k >= 2) checkOutput("fair_no_idle", 64'(cdb_en_o), 64'd1);
        end
        tick();
        checkOutput("fair_end_en", 64'(cdb_en_o), 64'd0);
        waitDrain("fair_drain", 10);

        // Backpressure: all FUs saturate for 8 edges; each gets 6 accepted.
        doReset();
        for (int k = 0; k < 6; k++) begin
            expect_bc(SRC_ALU, 5'(1 + k));
            expect_bc(SRC_MUL, 5'(9 + k));
            expect_bc(SRC_LSU, 5'(17 + k));
        end
        a_tag = 1; m_tag = 9; l_tag = 17;
        a_cnt = 0; m_cnt = 0; l_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            acc = {lsu_ready_o, mul_ready_o, alu_ready_o};
            applyStimulus(3'b111, 5'(a_tag), 5'(m_tag), 5'(l_tag), 1'b0);
            if (acc[0]) begin a_tag++; a_cnt++; end
            if (acc[1]) begin m_tag++; m_cnt++; end
            if (acc[2]) begin l_tag++; l_cnt++; end
            if (k == 4) checkOutput("bp_mul_ready_e4", 64'(mul_ready_o), 64'd1);
            if (k == 5) checkOutput("bp_mul_ready_e5", 64'(mul_ready_o), 64'd0);
            if (k == 6) checkOutput("bp_alu_ready_e6", 64'(alu_ready_o), 64'd0);
        end
        checkOutput("bp_alu_accepted", 64'(a_cnt), 64'd6);
        checkOutput("bp_mul_accepted", 64'(m_cnt), 64'd6);
        checkOutput("bp_lsu_accepted", 64'(l_cnt), 64'd6);
        waitDrain("bp_drain", 60);

        // Flush: third ALU result and the simultaneous LSU result vanish.
        doReset();
        expect_bc(SRC_ALU, 5'd1);
        expect_bc(SRC_ALU, 5'd2);
        applyStimulus(3'b001, 5'd1, 5'd0, 5'd0, 1'b0);
        applyStimulus(3'b001, 5'd2, 5'd0, 5'd0, 1'b0);
        applyStimulus(3'b001, 5'd3, 5'd0, 5'd0, 1'b0);
        applyStimulus(3'b100, 5'd0, 5'd0, 5'd25, 1'b1);
        checkOutput("flush_en",    64'(cdb_en_o), 64'd0);
        checkOutput("flush_ready", 64'({lsu_ready_o, mul_ready_o, alu_ready_o}), 64'b111);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("flush_idle_en", 64'(cdb_en_o), 64'd0);
        end
        // rr_ptr was left at MUL before the flush; ALU must now win first.
        expect_bc(SRC_ALU, 5'd5);
        expect_bc(SRC_MUL, 5'd13);
        applyStimulus(3'b011, 5'd5, 5'd13, 5'd0, 1'b0);
        waitDrain("flush_drain", 20);

        // Async reset between edges while all queues hold results.
        doReset();
        expect_bc(SRC_ALU, 5'd2);
        expect_bc(SRC_MUL, 5'd10);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(3'b111, 5'(2 + k), 5'(10 + k), 5'(18 + k), 1'b0);
        end
        @(negedge clk_i);
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("areset_en",    64'(cdb_en_o), 64'd0);
        checkOutput("areset_ready", 64'({lsu_ready_o, mul_ready_o, alu_ready_o}), 64'b111);
        tick();
        reset_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("areset_idle_en", 64'(cdb_en_o), 64'd0);
        end
        expect_bc(SRC_ALU, 5'd6);
        expect_bc(SRC_MUL, 5'd14);
        expect_bc(SRC_LSU, 5'd22);
        applyStimulus(3'b111, 5'd6, 5'd14, 5'd22, 1'b0);
        waitDrain("areset_drain", 20);
`endif

        checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Producer end of the common data bus (CDB) that the reservation stations snoop for wakeup.
- Accepts completed results from the ALU, MUL and LSU functional units and buffers each unit's results in its own FIFO.
- Grants one result per cycle using round-robin arbitration and broadcasts the winner's tag and data on registered CDB outputs.
- Sits between the FU writeback ports and the RS/ROB/regfile CDB consumers.

Parameters:
- FIFO_DEPTH, 4, entries per FU result queue; power of two, at least 2.
- TAG_W, 5, physical destination tag width.
- DATA_W, 32, result data width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous flush; drops all queued results.
- alu_valid_i  in  1  ALU result valid.
- alu_tag_i  in  TAG_W  ALU destination tag.
- alu_data_i  in  DATA_W  ALU result.
- alu_ready_o  out  1  ALU queue can accept a result.
- mul_valid_i / mul_tag_i / mul_data_i / mul_ready_o: same as ALU, for MUL.
- lsu_valid_i / lsu_tag_i / lsu_data_i / lsu_ready_o: same as ALU, for LSU.
- cdb_en_o  out  1  broadcast valid.
- cdb_tag_o  out  TAG_W  broadcast tag.
- cdb_data_o  out  DATA_W  broadcast data.
- cdb_src_o  out  2  source of the broadcast: 0 = ALU, 1 = MUL, 2 = LSU.

Behaviour:
- Reset (async, reset_i=1):
  - All queues empty; rr_ptr=0.
  - cdb_en_o=0, cdb_tag_o=0, cdb_data_o=0, cdb_src_o=0.
  - All *_ready_o=1 immediately after reset.
- Handshake: a result is accepted at a clock edge when x_valid_i & x_ready_o.
  - x_ready_o = (count_x < FIFO_DEPTH), derived from registered count only; no combinational path from any valid input.
  - A full queue stays not-ready even when it is popped in the same cycle (no pop-through).
- Each queue is FIFO ordered: results from one FU broadcast in acceptance order.
- Push and pop on the same queue in the same cycle: count unchanged; the pointers wrap modulo FIFO_DEPTH.
- Arbitration, evaluated each cycle:
  - Candidates are the non-empty queues.
  - Search order is rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); the first non-empty queue wins.
  - At the edge, the winner's head is popped and loaded into the output registers with cdb_en_o=1.
  - rr_ptr becomes (winner+1) mod 3.
  - If no candidate exists: cdb_en_o=0, tag/data/src hold their previous values, and rr_ptr holds.
- Throughput: at most one broadcast per cycle. A continuously non-empty queue is granted at least once every 3 cycles.
- Latency without bypass: result accepted at edge N reaches the FIFO head; earliest cdb_en_o=1 is after edge N+1, i.e. 2 cycles.
- flush_i=1 at an edge:
  - All queues are emptied; cdb_en_o=0 after the edge; rr_ptr is reset to 0.
  - Results presented in the same cycle are discarded, even if ready was high.
  - flush_i has priority over push and pop.
- Reset asserted mid-operation: all contents are lost immediately (asynchronous); no broadcast occurs until new results arrive.

Optional Feature:
- CDB_BYPASS_EN defined:
  - An incoming valid result on an empty queue is an arbitration candidate in the same cycle, ahead of buffering.
  - If it wins, it is broadcast after edge N (1-cycle latency) and is not written into the queue.
  - If it loses, it is enqueued normally.
  - Round-robin rules are unchanged.
  - This adds a combinational path from valid/tag/data inputs to the output registers' D inputs, but not to ready.
- CDB_BYPASS_EN undefined: only queue heads are candidates; minimum latency is 2 cycles.

Decomposition:
- Shared package cdb_pkg: TAG_W, DATA_W, the source IDs SRC_ALU=0 / SRC_MUL=1 / SRC_LSU=2, and a cdb_bus_t struct {en, tag, data, src} reused by the RS consumers.
- Sub-module cdb_result_fifo, parameterised by FIFO_DEPTH/TAG_W/DATA_W, with push, pop, flush, head, count and full. It is instantiated once per FU.
- Arbitration and output registers stay in the top level.

Test Plan:
- Single result, bypass off: after reset, alu_valid_i=1, tag=5'd7, data=32'hDEAD_BEEF for one cycle. Required: cdb_en_o=1 exactly 2 cycles later with tag 7, data DEADBEEF, src 0; cdb_en_o=0 the following cycle.
- Fairness: all three FUs push 4 results each in the same cycles (tags ALU 1-4, MUL 9-12, LSU 17-20). Required broadcast tag order: 1, 9, 17, 2, 10, 18, 3, 11, 19, 4, 12, 20, with no idle cycles.
- Backpressure: hold mul_valid_i=1 every cycle with LSU and ALU also saturating. Required: mul_ready_o drops to 0 when the MUL count reaches 4; no result is lost or duplicated; per-FU tag order is preserved.
- Flush: queue 3 ALU results, then assert flush_i for one cycle together with a new lsu_valid_i. Required: cdb_en_o=0 on the next cycle and all later cycles; all ready outputs are 1; the LSU result is never broadcast.
- Async reset mid-burst: assert reset_i between clock edges while queues are non-empty. Required: cdb_en_o=0 immediately, no later broadcasts, and the next accepted ALU result is granted first (rr_ptr=0).
- Bypass (CDB_BYPASS_EN defined): push one LSU result with tag 5'd3 while all queues are empty. Required: cdb_en_o=1 with tag 3 after 1 cycle; a simultaneous ALU push with rr_ptr=0 wins and the LSU result is broadcast on the following cycle.
